// File: rtl/photo_reader_pkg.sv
// Shared types and constants for the G-15 phototape reader emulator.
// The RWND state exists only when PHOTO_READER_REWIND_EN is defined.
package photo_reader_pkg;

  // One tape frame: bit 0 drives PHOTO1, bit 4 drives PHOTO5.
  typedef logic [4:0] photo_frame_t;

  // Cycles spent per frame while rewinding.
  localparam int RWND_STEP = 8;

`ifdef PHOTO_READER_REWIND_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_GAP   = 3'd2,
    ST_HOLE  = 3'd3,
    ST_RWND  = 3'd4
  } photo_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_GAP   = 3'd2,
    ST_HOLE  = 3'd3
  } photo_state_t;
`endif

  // Larger of two integers, used to size the shared phase counter.
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/photo_reader_emu_ram.sv
// tape_frame_ram: DEPTH x 5-bit tape image with one write port and one
// synchronous read port. The read register doubles as the PHOTO1..5
// output register, so it has a synchronous clear and an async reset.
module tape_frame_ram
  import photo_reader_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [4:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          rclr,
  output logic [4:0]    rdata
);

  photo_frame_t mem_r [DEPTH];
  photo_frame_t rdata_r;

  // Write port: append path from the host loader.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: clear wins over a read, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 5'd0;
    end else if (rclr) begin
      rdata_r <= 5'd0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/photo_reader_emu.sv
// photo_reader_emu: G-15 phototape reader emulator. Holds a host-loaded
// tape image and steps a cursor forward/backward at mechanical frame rate,
// presenting each frame on PHOTO1..5 during its hole window.
// Optional feature macro: PHOTO_READER_REWIND_EN (adds REWIND port and RWND).
module photo_reader_emu
  import photo_reader_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int FRAME_CYCLES = 2000,
  parameter int HOLE_CYCLES  = 500,
  parameter int START_CYCLES = 4000
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  input  logic                   PHOTO_TAPE_FWD,
  input  logic                   PHOTO_TAPE_REV,
  output logic                   PHOTO1,
  output logic                   PHOTO2,
  output logic                   PHOTO3,
  output logic                   PHOTO4,
  output logic                   PHOTO5,
  input  logic                   LOAD_CLR,
  input  logic                   LOAD_WE,
  input  logic [4:0]             LOAD_DATA,
  output logic                   LOAD_FULL,
  output logic [$clog2(DEPTH):0] TAPE_LEN,
  output logic [$clog2(DEPTH):0] TAPE_POS,
  output logic                   AT_BOT,
  output logic                   AT_EOT
`ifdef PHOTO_READER_REWIND_EN
  ,
  input  logic                   REWIND
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int PMAX = imax(imax(START_CYCLES, FRAME_CYCLES), RWND_STEP);
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] ACCEL_LAST = PW'(START_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(FRAME_CYCLES - HOLE_CYCLES - 1);
  localparam logic [PW-1:0] HOLE_LAST  = PW'(HOLE_CYCLES - 1);
  localparam logic [PW-1:0] RWND_LAST  = PW'(RWND_STEP - 1);
  localparam logic [PW-1:0] PH_ONE     = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] L_ONE      = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] L_ZERO     = {LW{1'b0}};
  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

  photo_state_t  state_r, state_s;
  logic [PW-1:0] phase_r;
  logic [LW-1:0] pos_r, len_r, pos_dec_s;
  logic          dir_rev_r;

  logic          fwd_s, rev_s, full_s, eot_s, bot_s, abort_s, end_s;
  logic          phase_zero_s, start_s, start_rev_s, hole_entry_s;
  logic          photo_clr_s, rwnd_step_s, ram_we_s;
  logic [AW-1:0] rd_addr_s;
  logic [4:0]    photo_s;

  // Both or neither direction line means "stop".
  assign fwd_s     = PHOTO_TAPE_FWD & ~PHOTO_TAPE_REV;
  assign rev_s     = PHOTO_TAPE_REV & ~PHOTO_TAPE_FWD;
  assign full_s    = (len_r == DEPTH_L);
  assign eot_s     = (pos_r == len_r);
  assign bot_s     = (pos_r == L_ZERO);
  assign pos_dec_s = pos_r - L_ONE;
  // Any loss of the latched direction aborts motion.
  assign abort_s   = dir_rev_r ? ~rev_s : ~fwd_s;
  // End of tape in the direction of travel, checked when a hole window ends.
  assign end_s     = dir_rev_r ? bot_s : eot_s;
  assign ram_we_s  = LOAD_WE & ~full_s & ~LOAD_CLR;

  // Next-state and control strobes for the motion FSM.
  always_comb begin
    state_s      = state_r;
    phase_zero_s = 1'b0;
    start_s      = 1'b0;
    start_rev_s  = 1'b0;
    hole_entry_s = 1'b0;
    photo_clr_s  = 1'b0;
    rwnd_step_s  = 1'b0;
    if (LOAD_CLR) begin
      state_s      = ST_IDLE;
      phase_zero_s = 1'b1;
      photo_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          phase_zero_s = 1'b1;
          if (fwd_s && !eot_s) begin
            state_s = ST_ACCEL;
            start_s = 1'b1;
          end else if (rev_s && !bot_s) begin
            state_s     = ST_ACCEL;
            start_s     = 1'b1;
            start_rev_s = 1'b1;
`ifdef PHOTO_READER_REWIND_EN
          end else if (REWIND && !bot_s && !fwd_s && !rev_s) begin
            state_s = ST_RWND;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ACCEL: begin
          if (abort_s) begin
            state_s      = ST_IDLE;
            phase_zero_s = 1'b1;
            photo_clr_s  = 1'b1;
          end else if (phase_r == ACCEL_LAST) begin
            state_s      = ST_GAP;
            phase_zero_s = 1'b1;
          end else begin
            state_s = ST_ACCEL;
          end
        end
        ST_GAP: begin
          if (abort_s) begin
            state_s      = ST_IDLE;
            phase_zero_s = 1'b1;
            photo_clr_s  = 1'b1;
          end else if (phase_r == GAP_LAST) begin
            // Read address goes out now; data lands on PHOTO at HOLE entry.
            state_s      = ST_HOLE;
            phase_zero_s = 1'b1;
            hole_entry_s = 1'b1;
          end else begin
            state_s = ST_GAP;
          end
        end
        ST_HOLE: begin
          if (abort_s) begin
            state_s      = ST_IDLE;
            phase_zero_s = 1'b1;
            photo_clr_s  = 1'b1;
          end else if (phase_r == HOLE_LAST) begin
            phase_zero_s = 1'b1;
            photo_clr_s  = 1'b1;
            if (end_s) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_GAP;
            end
          end else begin
            state_s = ST_HOLE;
          end
        end
`ifdef PHOTO_READER_REWIND_EN
        ST_RWND: begin
          if (fwd_s || rev_s || bot_s) begin
            state_s      = ST_IDLE;
            phase_zero_s = 1'b1;
          end else if (phase_r == RWND_LAST) begin
            phase_zero_s = 1'b1;
            rwnd_step_s  = 1'b1;
            if (pos_r == L_ONE) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_RWND;
            end
          end else begin
            state_s = ST_RWND;
          end
        end
`endif
        default: begin
          state_s      = ST_IDLE;
          phase_zero_s = 1'b1;
          photo_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Frame read address: forward reads the frame ahead, reverse the one behind.
  always_comb begin
    if (dir_rev_r) begin
      rd_addr_s = pos_dec_s[AW-1:0];
    end else begin
      rd_addr_s = pos_r[AW-1:0];
    end
  end

  // FSM state, phase counter and latched direction.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= {PW{1'b0}};
      dir_rev_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (phase_zero_s) begin
        phase_r <= {PW{1'b0}};
      end else begin
        phase_r <= phase_r + PH_ONE;
      end
      if (start_s) begin
        dir_rev_r <= start_rev_s;
      end else begin
        dir_rev_r <= dir_rev_r;
      end
    end
  end

  // Tape cursor and image length.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      pos_r <= L_ZERO;
      len_r <= L_ZERO;
    end else if (LOAD_CLR) begin
      pos_r <= L_ZERO;
      len_r <= L_ZERO;
    end else begin
      if (hole_entry_s && dir_rev_r) begin
        pos_r <= pos_dec_s;
      end else if (hole_entry_s) begin
        pos_r <= pos_r + L_ONE;
      end else if (rwnd_step_s) begin
        pos_r <= pos_dec_s;
      end else begin
        pos_r <= pos_r;
      end
      if (ram_we_s) begin
        len_r <= len_r + L_ONE;
      end else begin
        len_r <= len_r;
      end
    end
  end

  // Registered status outputs, one cycle behind the internal counters.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      TAPE_POS  <= L_ZERO;
      TAPE_LEN  <= L_ZERO;
      AT_BOT    <= 1'b1;
      AT_EOT    <= 1'b1;
      LOAD_FULL <= 1'b0;
    end else begin
      TAPE_POS  <= pos_r;
      TAPE_LEN  <= len_r;
      AT_BOT    <= bot_s;
      AT_EOT    <= eot_s;
      LOAD_FULL <= full_s;
    end
  end

  tape_frame_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLOCK),
    .rst   (rst),
    .we    (ram_we_s),
    .waddr (len_r[AW-1:0]),
    .wdata (LOAD_DATA),
    .re    (hole_entry_s),
    .raddr (rd_addr_s),
    .rclr  (photo_clr_s),
    .rdata (photo_s)
  );

  assign PHOTO1 = photo_s[0];
  assign PHOTO2 = photo_s[1];
  assign PHOTO3 = photo_s[2];
  assign PHOTO4 = photo_s[3];
  assign PHOTO5 = photo_s[4];

endmodule

// File: tb/tb_photo_reader_emu.sv
// Self-checking bench for photo_reader_emu with shortened timing parameters.
// The reference model is the tape as a queue plus a cursor; expected PHOTO
// values are computed from the frame-time arithmetic of the reader.
module tb_photo_reader_emu;

  localparam int DEPTH = 16;
  localparam int FRAME = 20;
  localparam int HOLE  = 5;
  localparam int START = 30;
  localparam int LAT   = 1 + START + FRAME - HOLE;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLOCK = 1'b0;
  logic          rst, fwd, rev, load_clr, load_we, rewind;
  logic [4:0]    load_data;
  logic          p1, p2, p3, p4, p5, load_full, at_bot, at_eot;
  logic [LW-1:0] tape_len, tape_pos;
  logic [4:0]    photo;

  assign photo = {p5, p4, p3, p2, p1};

  photo_reader_emu #(
    .DEPTH(DEPTH), .FRAME_CYCLES(FRAME), .HOLE_CYCLES(HOLE), .START_CYCLES(START)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .PHOTO_TAPE_FWD(fwd), .PHOTO_TAPE_REV(rev),
    .PHOTO1(p1), .PHOTO2(p2), .PHOTO3(p3), .PHOTO4(p4), .PHOTO5(p5),
    .LOAD_CLR(load_clr), .LOAD_WE(load_we), .LOAD_DATA(load_data),
    .LOAD_FULL(load_full), .TAPE_LEN(tape_len), .TAPE_POS(tape_pos),
    .AT_BOT(at_bot), .AT_EOT(at_eot)
`ifdef PHOTO_READER_REWIND_EN
    , .REWIND(rewind)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int checks   = 0;
  int failures = 0;
  logic [4:0] tape[$];
  int mpos = 0;

  typedef struct {
    logic       clr;
    logic       we;
    logic [4:0] data;
    int         exp_len;
    logic       exp_bot;
    logic       exp_eot;
    logic       exp_full;
  } load_vec_t;

  load_vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_len"},  int'(tape_len), tape.size());
    check({tag, "_pos"},  int'(tape_pos), mpos);
    check({tag, "_bot"},  int'(at_bot), (mpos == 0) ? 1 : 0);
    check({tag, "_eot"},  int'(at_eot), (mpos == tape.size()) ? 1 : 0);
    check({tag, "_full"}, int'(load_full), (tape.size() == DEPTH) ? 1 : 0);
  endtask

  // Append frames back to back, then let the status outputs settle.
  task automatic load_frames(input int n, input bit rnd, input logic [4:0] d);
    for (int i = 0; i < n; i++) begin
      load_we   = 1'b1;
      load_data = rnd ? 5'($urandom_range(0, 31)) : d;
      if (tape.size() < DEPTH) tape.push_back(load_data);
      tick();
    end
    load_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_clear();
    load_clr = 1'b1;
    tick();
    load_clr = 1'b0;
    tape.delete();
    mpos = 0;
    tick();
    tick();
  endtask

  // Hold one direction for k_max cycles, checking PHOTO every cycle.
  task automatic run_motion(input bit dir_rev, input int k_max, input string tag);
    int nf, j, ex, delivered;
    nf  = dir_rev ? mpos : (tape.size() - mpos);
    fwd = !dir_rev;
    rev = dir_rev;
    for (int k = 1; k <= k_max; k++) begin
      tick();
      ex = 0;
      if (k >= LAT && ((k - LAT) % FRAME) < HOLE) begin
        j = (k - LAT) / FRAME;
        if (j < nf) ex = dir_rev ? int'(tape[mpos - 1 - j]) : int'(tape[mpos + j]);
      end
      check({tag, "_photo"}, int'(photo), ex);
    end
    fwd = 1'b0;
    rev = 1'b0;
    tick();
    check({tag, "_photo_stop"}, int'(photo), 0);
    delivered = (k_max >= LAT) ? ((k_max - LAT) / FRAME + 1) : 0;
    if (delivered > nf) delivered = nf;
    mpos = dir_rev ? (mpos - delivered) : (mpos + delivered);
    tick();
    tick();
    check_status(tag);
  endtask

  initial begin
    vecs[0] = '{clr: 1'b1, we: 1'b0, data: 5'h00, exp_len: 0, exp_bot: 1'b1, exp_eot: 1'b1, exp_full: 1'b0};
    vecs[1] = '{clr: 1'b0, we: 1'b1, data: 5'h01, exp_len: 1, exp_bot: 1'b1, exp_eot: 1'b0, exp_full: 1'b0};
    vecs[2] = '{clr: 1'b0, we: 1'b1, data: 5'h1F, exp_len: 2, exp_bot: 1'b1, exp_eot: 1'b0, exp_full: 1'b0};
    vecs[3] = '{clr: 1'b0, we: 1'b1, data: 5'h0A, exp_len: 3, exp_bot: 1'b1, exp_eot: 1'b0, exp_full: 1'b0};
    vecs[4] = '{clr: 1'b0, we: 1'b0, data: 5'h13, exp_len: 3, exp_bot: 1'b1, exp_eot: 1'b0, exp_full: 1'b0};

    rst = 1'b1; fwd = 1'b0; rev = 1'b0; load_clr = 1'b0; load_we = 1'b0;
    load_data = 5'd0; rewind = 1'b0;
    tick();
    tick();
    check("reset_photo", int'(photo), 0);
    check_status("reset");
    rst = 1'b0;
    tick();

    // Table-driven load sequence.
    for (int i = 0; i < 5; i++) begin
      load_clr  = vecs[i].clr;
      load_we   = vecs[i].we;
      load_data = vecs[i].data;
      if (vecs[i].clr) begin tape.delete(); mpos = 0; end
      else if (vecs[i].we && tape.size() < DEPTH) tape.push_back(vecs[i].data);
      tick();
      load_clr = 1'b0;
      load_we  = 1'b0;
      tick();
      check("vec_len",  int'(tape_len),  vecs[i].exp_len);
      check("vec_bot",  int'(at_bot),    int'(vecs[i].exp_bot));
      check("vec_eot",  int'(at_eot),    int'(vecs[i].exp_eot));
      check("vec_full", int'(load_full), int'(vecs[i].exp_full));
    end

    // Full forward pass, then full reverse pass.
    run_motion(1'b0, LAT + 2 * FRAME + HOLE + 10, "fwd3");
    check("fwd3_pos_end", int'(tape_pos), 3);
    run_motion(1'b1, LAT + 2 * FRAME + HOLE + 10, "rev3");
    check("rev3_bot_end", int'(at_bot), 1);

    // Both directions asserted: no motion at all.
    fwd = 1'b1;
    rev = 1'b1;
    for (int k = 0; k < LAT + 10; k++) begin
      tick();
      check("both_photo", int'(photo), 0);
    end
    fwd = 1'b0;
    rev = 1'b0;
    tick();
    check_status("both");

    // Drop mid-GAP after one frame, restart, then drop mid-HOLE in reverse.
    run_motion(1'b0, LAT + 10, "drop_gap");
    check("drop_gap_pos", int'(tape_pos), 1);
    run_motion(1'b0, LAT + FRAME + HOLE + 10, "restart");
    run_motion(1'b1, LAT + 2, "drop_hole");
    run_motion(1'b1, LAT + FRAME + HOLE + 10, "rev_rest");

    // Fill to capacity; extra write is ignored.
    do_clear();
    load_frames(DEPTH, 1'b1, 5'd0);
    check("full_flag", int'(load_full), 1);
    load_frames(1, 1'b0, 5'h07);
    check("full_len", int'(tape_len), DEPTH);
    check_status("full");
    run_motion(1'b0, LAT + (DEPTH - 1) * FRAME + HOLE + 5, "fwd_all");

    // LOAD_CLR while moving in reverse, mid-HOLE.
    rev = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) tick();
    check("clr_pre_photo", int'(photo), int'(tape[DEPTH - 1]));
    load_clr = 1'b1;
    tick();
    load_clr = 1'b0;
    check("clr_photo", int'(photo), 0);
    tape.delete();
    mpos = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      check("clr_idle_photo", int'(photo), 0);
    end
    rev = 1'b0;
    tick();
    check_status("clr");

    // Randomized loads and motion against the model.
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          load_frames($urandom_range(1, 4), 1'b1, 5'd0);
          check_status("rnd_load");
        end
        1: run_motion(1'b0, $urandom_range(10, 130), "rnd_fwd");
        default: run_motion(1'b1, $urandom_range(10, 130), "rnd_rev");
      endcase
    end

`ifdef PHOTO_READER_REWIND_EN
    // Rewind from position 3: one step every 8 cycles, PHOTO stays dark.
    do_clear();
    load_frames(3, 1'b1, 5'd0);
    run_motion(1'b0, LAT + 2 * FRAME + HOLE + 5, "rw_setup");
    rewind = 1'b1;
    tick();
    rewind = 1'b0;
    for (int k = 2; k <= 32; k++) begin
      int st;
      tick();
      st = (k - 2) / 8;
      if (st > 3) st = 3;
      check("rw_photo", int'(photo), 0);
      check("rw_pos", int'(tape_pos), 3 - st);
    end
    mpos = 0;
    check_status("rw_end");
`endif

    // Reset asserted mid-HOLE with 5'b10101 on PHOTO.
    do_clear();
    load_frames(1, 1'b0, 5'h15);
    fwd = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) tick();
    check("rst_pre_photo", int'(photo), 21);
    #2;
    rst = 1'b1;
    #1;
    tape.delete();
    mpos = 0;
    check("rst_photo", int'(photo), 0);
    check_status("rst_mid");
    fwd = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_after_photo", int'(photo), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/photo_reader_emu.md
# photo_reader_emu

Emulates the G-15 built-in phototape reader for the I/O section. It stores a host-loaded tape image of 5-bit frames and moves a tape cursor forward or backward under the I/O section's PHOTO_TAPE_FWD / PHOTO_TAPE_REV commands. It presents each frame's hole pattern on PHOTO1..PHOTO5 at mechanical frame rate. Sits directly upstream of the I/O section's phototape input path.

## Interface
- DEPTH, 4096: tape image capacity in frames (power of two).
- FRAME_CYCLES, 2000: CLOCK cycles per frame period.
- HOLE_CYCLES, 500: cycles a frame's code is held on PHOTO1..5 (< FRAME_CYCLES).
- START_CYCLES, 4000: cycles of acceleration between motion start and first frame window.
- CLOCK  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- PHOTO_TAPE_FWD  in  1  drive tape forward (level).
- PHOTO_TAPE_REV  in  1  drive tape reverse (level).
- PHOTO1, PHOTO2, PHOTO3, PHOTO4, PHOTO5  out  1 each  hole sensed in channel 1..5; zero outside hole window.
- LOAD_CLR  in  1  empty the tape image and rewind the cursor.
- LOAD_WE  in  1  append LOAD_DATA to the image.
- LOAD_DATA  in  5  frame to append (bit 0 → PHOTO1).
- LOAD_FULL  out  1  image length == DEPTH.
- TAPE_LEN  out  $clog2(DEPTH)+1  frames loaded.
- TAPE_POS  out  $clog2(DEPTH)+1  cursor (0..TAPE_LEN), between frames.
- AT_BOT  out  1  TAPE_POS == 0.
- AT_EOT  out  1  TAPE_POS == TAPE_LEN.
- REWIND  in  1  (only with PHOTO_READER_REWIND_EN) fast return to BOT.

## Operation
- States: IDLE, ACCEL, GAP, HOLE (plus RWND under macro).
- Motion request: FWD = PHOTO_TAPE_FWD & ~PHOTO_TAPE_REV; REV = PHOTO_TAPE_REV & ~PHOTO_TAPE_FWD; both or neither means stop.
- IDLE → ACCEL on a motion request, unless blocked (FWD & AT_EOT, or REV & AT_BOT). Blocked requests stay in IDLE.
- ACCEL runs START_CYCLES cycles, then → GAP.
- GAP runs FRAME_CYCLES−HOLE_CYCLES cycles, then → HOLE.
- HOLE entry, forward: PHOTO1..5 ← mem[TAPE_POS]; TAPE_POS++.
- HOLE entry, reverse: PHOTO1..5 ← mem[TAPE_POS−1]; TAPE_POS−−.
- Forward then reverse re-reads the same frame.
- HOLE runs HOLE_CYCLES cycles, then PHOTO1..5 ← 0 and → GAP. If the end is now reached in the current direction, → IDLE instead.
- Motion request dropped or direction changed in any state: → IDLE next cycle and PHOTO1..5 ← 0. A new request restarts through ACCEL.
- Cursor changes only at HOLE entry.
- Load: LOAD_WE writes mem[TAPE_LEN] and increments TAPE_LEN. The write is ignored when LOAD_FULL. Writes are accepted in any state and never touch frames already loaded.
- LOAD_CLR has priority over LOAD_WE and motion. It zeroes TAPE_LEN and TAPE_POS, zeroes PHOTO1..5 and forces IDLE.
- Reset values: state IDLE, PHOTO1..5 = 0, TAPE_LEN = 0, TAPE_POS = 0, AT_BOT = 1, AT_EOT = 1, LOAD_FULL = 0.

## Timing
- Motion request to first HOLE entry: 1 + START_CYCLES + (FRAME_CYCLES−HOLE_CYCLES) cycles.
- After the first frame, HOLE entries are exactly FRAME_CYCLES apart.
- RAM read is synchronous, 1 cycle. The address is issued on the last GAP cycle and the data is registered into PHOTO1..5 on HOLE entry.
- All outputs are registered. Status outputs (AT_BOT, AT_EOT, TAPE_POS) update the cycle after HOLE entry or load.
- A simultaneous LOAD_WE and HOLE entry is legal. A forward read of mem[TAPE_POS] where TAPE_POS == TAPE_LEN cannot occur, because AT_EOT blocks it.

## Configuration
- PHOTO_READER_REWIND_EN defined:
  - The REWIND port exists.
  - IDLE & REWIND & ~AT_BOT → RWND.
  - RWND decrements TAPE_POS by one every 8 cycles with PHOTO1..5 held 0, and → IDLE at BOT.
  - Any FWD/REV request aborts RWND to IDLE.
- PHOTO_READER_REWIND_EN undefined: no REWIND port and no RWND state.

## Structure
- Package photo_reader_pkg holds:
  - the state enum `photo_state_t`;
  - the frame typedef `photo_frame_t` (logic [4:0]);
  - the RWND step constant (8).
- Sub-module tape_frame_ram: DEPTH × 5 bits, one write port, one synchronous read port.
- Counters (phase, cursor, length) and the FSM live in photo_reader_emu.

## Test plan
- Reset mid-HOLE with PHOTO = 5'b10101 → all outputs return to their reset values immediately; TAPE_LEN = 0.
- Load 3 frames 5'h01, 5'h1F, 5'h0A, then FWD held → PHOTO shows 01, 1F, 0A, each for HOLE_CYCLES, at FRAME_CYCLES spacing. The first frame appears 1+START+FRAME−HOLE cycles after FWD. Then AT_EOT = 1, state IDLE, PHOTO = 0.
- From TAPE_POS = 3, REV held → frames 0A, 1F, 01 in that order, then AT_BOT = 1. With FWD and REV both high → no motion, PHOTO = 0.
- FWD dropped mid-GAP after one frame → IDLE next cycle, TAPE_POS = 1. FWD reasserted → full ACCEL delay again, then frame 1F.
- Fill to DEPTH → LOAD_FULL = 1 and a further LOAD_WE leaves TAPE_LEN = DEPTH. LOAD_CLR during motion → TAPE_LEN = 0, TAPE_POS = 0, PHOTO = 0, IDLE.
- With PHOTO_READER_REWIND_EN, TAPE_POS = 3, REWIND pulse → TAPE_POS reaches 0 after 24 cycles with PHOTO = 0 throughout, then IDLE.
